// File: rtl/kuz_s_layer_seq_if.sv
// Block handshake bundle for the sequential Kuznyechik S-layer.
// The master side offers input blocks and accepts results; the slave side is the S-layer.
interface kuz_s_layer_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/kuz_s_layer_seq.sv
// Sequential Kuznyechik S-layer: LANES bytes per clock through pi^-1 (or pi when
// KUZ_S_FWD_EN is defined and the block's latched mode is 1).
module kuz_s_layer_seq #(
  parameter int LANES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  kuz_s_layer_seq_if.slave s_if
);

  localparam int N  = 16 / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("kuz_s_layer_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [7:0] PI_TAB [256] = '{
    8'd252, 8'd238, 8'd221, 8'd17,  8'd207, 8'd110, 8'd49,  8'd22,  8'd251, 8'd196, 8'd250, 8'd218, 8'd35,  8'd197, 8'd4,   8'd77,
    8'd233, 8'd119, 8'd240, 8'd219, 8'd147, 8'd46,  8'd153, 8'd186, 8'd23,  8'd54,  8'd241, 8'd187, 8'd20,  8'd205, 8'd95,  8'd193,
    8'd249, 8'd24,  8'd101, 8'd90,  8'd226, 8'd92,  8'd239, 8'd33,  8'd129, 8'd28,  8'd60,  8'd66,  8'd139, 8'd1,   8'd142, 8'd79,
    8'd5,   8'd132, 8'd2,   8'd174, 8'd227, 8'd106, 8'd143, 8'd160, 8'd6,   8'd11,  8'd237, 8'd152, 8'd127, 8'd212, 8'd211, 8'd31,
    8'd235, 8'd52,  8'd44,  8'd81,  8'd234, 8'd200, 8'd72,  8'd171, 8'd242, 8'd42,  8'd104, 8'd162, 8'd253, 8'd58,  8'd206, 8'd204,
    8'd181, 8'd112, 8'd14,  8'd86,  8'd8,   8'd12,  8'd118, 8'd18,  8'd191, 8'd114, 8'd19,  8'd71,  8'd156, 8'd183, 8'd93,  8'd135,
    8'd21,  8'd161, 8'd150, 8'd41,  8'd16,  8'd123, 8'd154, 8'd199, 8'd243, 8'd145, 8'd120, 8'd111, 8'd157, 8'd158, 8'd178, 8'd177,
    8'd50,  8'd117, 8'd25,  8'd61,  8'd255, 8'd53,  8'd138, 8'd126, 8'd109, 8'd84,  8'd198, 8'd128, 8'd195, 8'd189, 8'd13,  8'd87,
    8'd223, 8'd245, 8'd36,  8'd169, 8'd62,  8'd168, 8'd67,  8'd201, 8'd215, 8'd121, 8'd214, 8'd246, 8'd124, 8'd34,  8'd185, 8'd3,
    8'd224, 8'd15,  8'd236, 8'd222, 8'd122, 8'd148, 8'd176, 8'd188, 8'd220, 8'd232, 8'd40,  8'd80,  8'd78,  8'd51,  8'd10,  8'd74,
    8'd167, 8'd151, 8'd96,  8'd115, 8'd30,  8'd0,   8'd98,  8'd68,  8'd26,  8'd184, 8'd56,  8'd130, 8'd100, 8'd159, 8'd38,  8'd65,
    8'd173, 8'd69,  8'd70,  8'd146, 8'd39,  8'd94,  8'd85,  8'd47,  8'd140, 8'd163, 8'd165, 8'd125, 8'd105, 8'd213, 8'd149, 8'd59,
    8'd7,   8'd88,  8'd179, 8'd64,  8'd134, 8'd172, 8'd29,  8'd247, 8'd48,  8'd55,  8'd107, 8'd228, 8'd136, 8'd217, 8'd231, 8'd137,
    8'd225, 8'd27,  8'd131, 8'd73,  8'd76,  8'd63,  8'd248, 8'd254, 8'd141, 8'd83,  8'd170, 8'd144, 8'd202, 8'd216, 8'd133, 8'd97,
    8'd32,  8'd113, 8'd103, 8'd164, 8'd45,  8'd43,  8'd9,   8'd91,  8'd203, 8'd155, 8'd37,  8'd208, 8'd190, 8'd229, 8'd108, 8'd82,
    8'd89,  8'd166, 8'd116, 8'd210, 8'd230, 8'd244, 8'd180, 8'd192, 8'd209, 8'd102, 8'd175, 8'd194, 8'd57,  8'd75,  8'd99,  8'd182
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    work_q;
  logic [127:0]    work_d;
  logic            out_valid_q;
  logic            busy_q;
`ifdef KUZ_S_FWD_EN
  logic            mode_q;
`endif

  logic [7:0] pi_inv_tab [256];
  logic [7:0] lane_in    [LANES];
  logic [7:0] lane_out   [LANES];
  logic       accept;

  // pi^-1 is derived by inverting pi, so the two tables can never disagree.
  always_comb begin
    for (int j = 0; j < 256; j++) pi_inv_tab[j] = 8'h00;
    for (int j = 0; j < 256; j++) pi_inv_tab[PI_TAB[j]] = 8'(j);
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_in[gi] = work_q[(int'(cnt_q) * LANES + gi) * 8 +: 8];
`ifdef KUZ_S_FWD_EN
    assign lane_out[gi] = mode_q ? PI_TAB[lane_in[gi]] : pi_inv_tab[lane_in[gi]];
`else
    assign lane_out[gi] = pi_inv_tab[lane_in[gi]];
`endif
  end

  always_comb begin
    work_d = work_q;
    for (int l = 0; l < LANES; l++) work_d[(int'(cnt_q) * LANES + l) * 8 +: 8] = lane_out[l];
  end

  // Ready is released in DONE only together with the downstream handshake, so a new
  // block can overlap the drain of the previous one without a bubble.
  assign s_if.in_ready  = rst_n & ((state_q == IDLE) | ((state_q == DONE) & s_if.out_ready));
  assign accept         = s_if.in_valid & s_if.in_ready;
  assign s_if.out_valid = out_valid_q;
  assign s_if.out_data  = work_q;
  assign s_if.busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef KUZ_S_FWD_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            work_q  <= s_if.in_data;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef KUZ_S_FWD_EN
            mode_q  <= s_if.in_mode;
`endif
          end
        end
        RUN: begin
          work_q <= work_d;
          if (cnt_q == LAST_BEAT) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (s_if.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              work_q  <= s_if.in_data;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= RUN;
`ifdef KUZ_S_FWD_EN
              mode_q  <= s_if.in_mode;
`endif
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kuz_s_layer_seq.sv
// Directed bench for kuz_s_layer_seq: one instance per legal LANES value (1,2,4,8,16)
// sharing clock, reset and input data, each with its own valid/ready.
module tb_kuz_s_layer_seq;

  localparam logic [127:0] INV_IN  = 128'h559d8dd7bd06cbfe7e7b262523280d39;
  localparam logic [127:0] INV_OUT = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
  localparam logic [127:0] FWD_IN  = 128'hffeeddccbbaa99881122334455667700;
`ifdef KUZ_S_FWD_EN
  localparam logic [127:0] FWD_EXP = 128'hb66cd8887d38e8d77765aeea0c9a7efc;
`else
  localparam logic [127:0] FWD_EXP = 128'h7401024f1bda16cc038d9da7b6f911a5;
`endif
  localparam logic [127:0] ZERO_EXP = {16{8'ha5}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [4:0]   v;
  logic [4:0]   ordy;
  logic         mode;
  logic [127:0] din;
  logic [4:0]   rdy;
  logic [4:0]   ovalid;
  logic [4:0]   busy;
  logic [127:0] odata [5];

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 5; gi++) begin : g_dut
    kuz_s_layer_seq_if bus ();
    assign bus.in_valid  = v[gi];
    assign bus.in_mode   = mode;
    assign bus.in_data   = din;
    assign bus.out_ready = ordy[gi];
    assign rdy[gi]       = bus.in_ready;
    assign ovalid[gi]    = bus.out_valid;
    assign busy[gi]      = bus.busy;
    assign odata[gi]     = bus.out_data;

    kuz_s_layer_seq #(.LANES(1 << gi)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s_if  (bus.slave)
    );
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass_cnt++;
  endtask

  // Called at a falling edge; offers one block which the DUT takes at the next rising edge.
  task automatic launch(input int d, input logic m, input logic [127:0] data);
    v[d] = 1'b1;
    mode = m;
    din  = data;
    @(negedge clk);
    v[d] = 1'b0;
    mode = 1'($urandom);
    din  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts rising edges from the accept edge until out_valid, and busy cycles meanwhile.
  task automatic wait_result(input int d, input int n, input logic [127:0] exp, input string tag);
    int lat = 0;
    int bc  = 0;
    while (!ovalid[d] && lat < 40) begin
      if (busy[d]) bc++;
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_latency"}, 128'(lat), 128'(n));
    check_eq({tag, "_busy_cycles"}, 128'(bc), 128'(n));
    check_eq({tag, "_data"}, odata[d], exp);
    check_eq({tag, "_busy_done"}, 128'(busy[d]), 128'd0);
    $display("blk %s lanes=%0d lat=%0d busy=%0d out=%h", tag, 1 << d, lat, bc, odata[d]);
  endtask

  task automatic release_out(input int d, input string tag);
    ordy[d] = 1'b1;
    @(negedge clk);
    ordy[d] = 1'b0;
    check_eq({tag, "_valid_drop"}, 128'(ovalid[d]), 128'd0);
  endtask

  initial begin
    v     = '0;
    ordy  = '0;
    mode  = 1'b0;
    din   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 128'(rdy), 128'd0);
    check_eq("rst_out_valid", 128'(ovalid), 128'd0);
    check_eq("rst_busy", 128'(busy), 128'd0);
    check_eq("rst_data_l1", odata[0], 128'd0);
    check_eq("rst_data_l16", odata[4], 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", 128'(rdy), 128'h1f);

    launch(2, 1'b0, INV_IN);
    wait_result(2, 4, INV_OUT, "inv_vec");
    release_out(2, "inv_vec");

    launch(2, 1'b1, FWD_IN);
    wait_result(2, 4, FWD_EXP, "fwd_vec");
    release_out(2, "fwd_vec");

    for (int d = 0; d < 5; d++) begin
      launch(d, 1'b0, 128'd0);
      wait_result(d, 16 >> d, ZERO_EXP, $sformatf("zero_l%0d", 1 << d));
      release_out(d, $sformatf("zero_l%0d", 1 << d));
    end

    // Backpressure: result must hold while out_ready stays low.
    launch(2, 1'b0, INV_IN);
    wait_result(2, 4, INV_OUT, "bp_first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_hold_data", odata[2], INV_OUT);
      check_eq("bp_hold_valid", 128'(ovalid[2]), 128'd1);
      check_eq("bp_hold_in_ready", 128'(rdy[2]), 128'd0);
    end
    ordy[2] = 1'b1;
    v[2]    = 1'b1;
    mode    = 1'b0;
    din     = 128'd0;
    #1;
    check_eq("bp_overlap_in_ready", 128'(rdy[2]), 128'd1);
    @(negedge clk);
    ordy[2] = 1'b0;
    v[2]    = 1'b0;
    din     = {$urandom, $urandom, $urandom, $urandom};
    check_eq("bp_overlap_no_valid", 128'(ovalid[2]), 128'd0);
    check_eq("bp_overlap_busy", 128'(busy[2]), 128'd1);
    wait_result(2, 4, ZERO_EXP, "bp_second");
    release_out(2, "bp_second");

    // Reset pulsed after beats 0 and 1 of a LANES=1 block.
    launch(0, 1'b0, INV_IN);
    repeat (2) @(negedge clk);
    check_eq("mid_busy", 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 128'(ovalid[0]), 128'd0);
    check_eq("mid_rst_busy", 128'(busy[0]), 128'd0);
    check_eq("mid_rst_data", odata[0], 128'd0);
    check_eq("mid_rst_in_ready", 128'(rdy[0]), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_valid", 128'(ovalid[0]), 128'd0);
    check_eq("post_rst_busy", 128'(busy[0]), 128'd0);
    launch(0, 1'b0, INV_IN);
    wait_result(0, 16, INV_OUT, "post_rst");
    release_out(0, "post_rst");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
